// File: rtl/systolic_pkg.sv
// Package for the systolic array operand feeder.
// Contents: FSM state type, the nominal feed latency, and width/latency helpers.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Array side used when no override is given.
  localparam int DIMENSION_DEF = 4;

  // Edges from start to the last operand leaving the array.
  localparam int FEED_LATENCY  = 3 * DIMENSION_DEF;

  function automatic int feed_latency(input int n);
    return 3 * n;
  endfunction

  // The counter must reach 3N and still have headroom for the DONE cycle.
  function automatic int cnt_width(input int n);
    return $clog2(3 * n + 2);
  endfunction

endpackage

// File: rtl/systolic_feeder_ctrl_skew.sv
// skew_delay_line: reset-clearable shift chain of DEPTH registers.
// Ports: i_clock, i_reset_n (async low), i_d (WIDTH) in, o_q (WIDTH) out.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int s = 1; s < DEPTH; s++) r_pipe[s] <= r_pipe[s-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/systolic_feeder_ctrl.sv
// systolic_feeder_ctrl: reads N operand columns/rows from memory and feeds them
// into an N x N systolic array with a per-lane skew (lane i delayed i+1 stages).
// Ports:
//   i_clock, i_reset_n (async low), i_start      - control
//   o_busy, o_done, o_array_clear                - status / array control
//   o_rd_en, o_rd_addr[AW]                       - operand memory read
//   i_a_col, i_b_row [N*I_BITS]                  - read data (one cycle latency)
//   o_west, o_north [N*I_BITS]                   - skewed array streams
//   o_op_count[16]                               - only with SYSTOLIC_FEEDER_OPCNT_EN
module systolic_feeder_ctrl
  import systolic_pkg::*;
#(
  parameter int DIMENSION = 4,
  parameter int I_BITS    = 8,
  parameter int AW        = $clog2(DIMENSION)
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic                        i_start,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_rd_en,
  output logic [AW-1:0]               o_rd_addr,
  input  logic [DIMENSION*I_BITS-1:0] i_a_col,
  input  logic [DIMENSION*I_BITS-1:0] i_b_row,
  output logic [DIMENSION*I_BITS-1:0] o_west,
  output logic [DIMENSION*I_BITS-1:0] o_north,
  output logic                        o_array_clear
`ifdef SYSTOLIC_FEEDER_OPCNT_EN
  ,
  output logic [15:0]                 o_op_count
`endif
);

  localparam int CW = cnt_width(DIMENSION);
  localparam logic [CW-1:0] LOAD_END  = CW'(DIMENSION - 1);
  localparam logic [CW-1:0] DRAIN_END = CW'(feed_latency(DIMENSION) - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;     // edges since start
  logic            r_busy, r_done, r_rd_en, r_clear, r_rd_en_d;
  logic [AW-1:0]   r_rd_addr;

  // Outputs are computed for the cycle being entered, so every one is a flop.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_clear   <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_clear <= 1'b0;
      r_cnt   <= r_cnt + 1'b1;
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state   <= LOAD;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_rd_en   <= 1'b1;
            r_clear   <= 1'b1;
            r_rd_addr <= '0;
          end else begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        LOAD: begin
          if (r_cnt == LOAD_END) begin
            r_state   <= DRAIN;
            r_rd_addr <= '0;
          end else begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (r_cnt == DRAIN_END) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read data arrives one cycle after the strobe; this qualifies it.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_rd_en_d <= 1'b0;
    else            r_rd_en_d <= r_rd_en;
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_rd_en       = r_rd_en;
  assign o_rd_addr     = r_rd_addr;
  assign o_array_clear = r_clear;

  for (genvar g = 0; g < DIMENSION; g++) begin : g_lane
    logic [I_BITS-1:0] w_a, w_b;
    assign w_a = r_rd_en_d ? i_a_col[g*I_BITS +: I_BITS] : '0;
    assign w_b = r_rd_en_d ? i_b_row[g*I_BITS +: I_BITS] : '0;

    skew_delay_line #(.DEPTH(g + 1), .WIDTH(I_BITS)) u_west (
      .i_clock  (i_clock),
      .i_reset_n(i_reset_n),
      .i_d      (w_a),
      .o_q      (o_west[g*I_BITS +: I_BITS])
    );
    skew_delay_line #(.DEPTH(g + 1), .WIDTH(I_BITS)) u_north (
      .i_clock  (i_clock),
      .i_reset_n(i_reset_n),
      .i_d      (w_b),
      .o_q      (o_north[g*I_BITS +: I_BITS])
    );
  end

`ifdef SYSTOLIC_FEEDER_OPCNT_EN
  logic [15:0] r_op_count;
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)  r_op_count <= '0;
    else if (r_done) r_op_count <= r_op_count + 1'b1;
  end
  assign o_op_count = r_op_count;
`endif

endmodule
